// File: rtl/delay_line_reader.sv
// delay_line_reader: reads one delayed sample from a circular sample memory
// per audio tick and presents it on a valid/ready output.
// Optional build macro DLR_UNDERFLOW_MUTE_EN: count accepted ticks since arming.
// Output is zeroed while fewer ticks than the requested delay have been seen,
// so the delay line has not yet been filled.
module delay_line_reader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sample_tick,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic [ADDR_W-1:0] delay,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_ARMED = 3'd1;
  localparam logic [STATE_W-1:0] S_FETCH = 3'd2;
  localparam logic [STATE_W-1:0] S_WAIT  = 3'd3;
  localparam logic [STATE_W-1:0] S_HOLD  = 3'd4;

  logic [STATE_W-1:0] state_q, state_d;
  logic               mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  rdata_q;
  logic               wait_ph_q, wait_ph_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               en_prev_q;
  logic               en_rise;
  logic               tick_dropped;

`ifdef DLR_UNDERFLOW_MUTE_EN
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               mute_q, mute_d;
`endif

  assign en_rise = en & ~en_prev_q;

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      rdata_q     <= '0;
      wait_ph_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      en_prev_q   <= 1'b0;
`ifdef DLR_UNDERFLOW_MUTE_EN
      cnt_q       <= '0;
      mute_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      rdata_q     <= mem_rdata;
      wait_ph_q   <= wait_ph_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      en_prev_q   <= en;
`ifdef DLR_UNDERFLOW_MUTE_EN
      cnt_q       <= cnt_d;
      mute_q      <= mute_d;
`endif
    end
  end

  // Next-state and next-output logic. Read data is registered on entry
  // (rdata_q), so WAIT spans two cycles: one to land the memory word,
  // one to move it to the output, giving out_valid three edges after the tick.
  always_comb begin
    state_d      = state_q;
    mem_re_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    wait_ph_d    = wait_ph_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q;
    tick_dropped = 1'b0;
`ifdef DLR_UNDERFLOW_MUTE_EN
    cnt_d        = cnt_q;
    mute_d       = mute_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_ARMED;
`ifdef DLR_UNDERFLOW_MUTE_EN
          cnt_d   = '0;
`endif
        end
      end
      S_ARMED: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (sample_tick) begin
          mem_re_d   = 1'b1;
          mem_addr_d = wr_ptr - delay;
          state_d    = S_FETCH;
`ifdef DLR_UNDERFLOW_MUTE_EN
          mute_d     = (cnt_q < delay);
          if (cnt_q != {ADDR_W{1'b1}}) begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
`endif
        end
      end
      S_FETCH: begin
        tick_dropped = sample_tick;
        wait_ph_d    = 1'b0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        tick_dropped = sample_tick;
        if (!wait_ph_q) begin
          wait_ph_d = 1'b1;
        end else begin
          wait_ph_d   = 1'b0;
`ifdef DLR_UNDERFLOW_MUTE_EN
          out_data_d  = mute_q ? '0 : rdata_q;
`else
          out_data_d  = rdata_q;
`endif
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        tick_dropped = sample_tick;
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = en ? S_ARMED : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Re-enabling clears the sticky flag; a drop in the same cycle wins.
    if (en_rise) begin
      overrun_d = 1'b0;
    end
    if (tick_dropped) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_HOLD);
  end

  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/delay_line_reader.md
DELAY_LINE_READER -- requirements
Module: delay_line_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, the sample-memory address width; depth is 2^ADDR_W.
REQ-002 The block SHALL have parameter DATA_W, default 8, the sample width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  level enable; high arms the reader, low returns it to IDLE.
REQ-006 sample_tick  input  1  single-cycle strobe, one per audio sample.
REQ-007 wr_ptr  input  ADDR_W  the writer's current write address.
REQ-008 delay  input  ADDR_W  read offset behind wr_ptr, in samples.
REQ-009 mem_re  output  1  memory read strobe.
REQ-010 mem_addr  output  ADDR_W  memory read address.
REQ-011 mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_re.
REQ-012 out_data  output  DATA_W  delayed sample.
REQ-013 out_valid  output  1  out_data is valid.
REQ-014 out_ready  input  1  consumer accepts out_data.
REQ-015 busy  output  1  high in any state other than IDLE or ARMED.
REQ-016 overrun  output  1  sticky flag: a tick was dropped.

Function
REQ-017 The FSM SHALL have the states IDLE, ARMED, FETCH, WAIT and HOLD.
REQ-018 The FSM SHALL go IDLE->ARMED when en=1, and ARMED->IDLE when en=0.
REQ-019 In ARMED with sample_tick=1, the block SHALL latch mem_addr = (wr_ptr - delay) mod 2^ADDR_W, assert mem_re for exactly one cycle, and enter FETCH.
REQ-020 The FSM SHALL go FETCH->WAIT unconditionally.
REQ-021 In WAIT the block SHALL capture mem_rdata into out_data, set out_valid=1, and enter HOLD.
REQ-022 Latency: a tick sampled at edge E0 SHALL give mem_re high after E0 and out_valid high after E3.
REQ-023 In HOLD, out_valid and out_data SHALL stay stable until out_ready=1 is sampled.
REQ-024 On acceptance, out_valid SHALL clear at that edge; the next state is ARMED if en=1, else IDLE.
REQ-025 If out_valid=1 and out_ready=1 are already high on entry to HOLD, transfer SHALL complete at the next edge.
REQ-026 A sample_tick in FETCH, WAIT or HOLD SHALL be dropped and SHALL set overrun=1 until reset or an en 0->1 transition.
REQ-027 A tick coincident with acceptance in HOLD SHALL be dropped and SHALL set overrun.
REQ-028 en=0 during FETCH, WAIT or HOLD SHALL NOT abort the transaction; the block SHALL return to IDLE after acceptance.
REQ-029 delay=0 SHALL read address wr_ptr, i.e. the oldest sample, a full 2^ADDR_W delay.
REQ-030 Address subtraction SHALL wrap modulo 2^ADDR_W; no saturation.
REQ-031 wr_ptr and delay SHALL be sampled only on the accepted tick edge.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, mem_re=0, mem_addr=0, out_data=0, out_valid=0, busy=0 and overrun=0, including mid-transaction.
REQ-033 After rst_n rises, the block SHALL wait for en=1 to arm; a tick in IDLE SHALL be ignored and SHALL NOT set overrun.

Configuration
REQ-034 Macro DLR_UNDERFLOW_MUTE_EN, when defined, SHALL add a tick counter cleared on IDLE->ARMED that increments per accepted tick and saturates at 2^ADDR_W-1.
REQ-035 With the macro defined, while count < latched delay, out_data SHALL be 0; the read and handshake timing SHALL be unchanged.
REQ-036 With the macro undefined, the counter SHALL be absent and out_data SHALL always be memory contents.

Verification
REQ-037 Scenario 1: memory mem[k]=k[7:0], en=1, wr_ptr=0x0010, delay=0x0004, tick, out_ready=1 -> mem_addr=0x000C, out_data=0x0C, out_valid high 3 cycles after the tick edge for one cycle.
REQ-038 Scenario 2: wr_ptr=0x0002, delay=0x0005 -> mem_addr=0xFFFD, out_data=0xFD; delay=0 with wr_ptr=0x0002 -> mem_addr=0x0002.
REQ-039 Scenario 3: out_ready held 0 for 5 cycles after out_valid -> out_data and out_valid stable for 5 cycles, cleared the cycle after out_ready=1.
REQ-040 Scenario 4: second tick 1 cycle after the first -> single mem_re pulse, overrun=1 and stays 1; en 0->1 -> overrun=0.
REQ-041 Scenario 5: rst_n=0 asserted in WAIT -> out_valid, mem_re and busy go 0 without a clock edge; no output after release until en and tick.
REQ-042 Scenario 6 (DLR_UNDERFLOW_MUTE_EN): delay=3, memory all 0xAA, 4 ticks -> out_data 0x00, 0x00, 0x00, 0xAA.
